// File: rtl/bit_writer_pkg.sv
// Shared types and constants for the bit-mask write controller.
// The state encoding is kept here so the bench and any future siblings agree on it.
package bit_writer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } bw_state_t;

   localparam int BW_NBITS = 8;

endpackage

// File: rtl/bit_counter.sv
// Accepted-bit counter with synchronous clear and enable.
// The terminal flag marks the accept that completes the transfer.
module bit_counter #(
   parameter int NBITS = 8,
   parameter int CNT_W = $clog2(NBITS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             term
);

   // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Combinational so the controller can leave WRITE on the same accept edge.
   assign term = en && (cnt == CNT_W'(NBITS - 1));

endmodule

// File: rtl/bit_writer_ctrl.sv
// Control FSM feeding the datapath bit-mask write stage: accepts NBITS serial
// bits over valid/ready, strobes data/shift/wr per bit, pulses done at the end.
module bit_writer_ctrl
   import bit_writer_pkg::*;
#(
   parameter int NBITS = BW_NBITS,
   parameter int CNT_W = $clog2(NBITS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic             bit_ready,
   output logic             data,
   output logic             shift,
   output logic             rst_mask,
   output logic             wr,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bit_cnt
);

   bw_state_t state;
   bw_state_t state_next;

   logic accept;
   logic cnt_clr;
   logic cnt_term;

   bit_counter #(
      .NBITS (NBITS),
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (accept),
      .cnt  (bit_cnt),
      .term (cnt_term)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
      state_next = state;
      bit_ready  = 1'b0;
      accept     = 1'b0;
      data       = 1'b0;
      shift      = 1'b0;
      wr         = 1'b0;
      rst_mask   = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      cnt_clr    = 1'b0;

      unique case (state)
         IDLE: begin
            busy = 1'b0;
            // Abort beats start when both arrive together.
            if (start && !abort) begin
               state_next = LOAD;
            end
         end

         LOAD: begin
            rst_mask   = 1'b1;
            cnt_clr    = 1'b1;
            state_next = abort ? IDLE : WRITE;
         end

         WRITE: begin
            if (abort) begin
               // Already-written bits stay in the datapath byte; only the mask is rewound.
               rst_mask   = 1'b1;
               cnt_clr    = 1'b1;
               state_next = IDLE;
            end else begin
               bit_ready = 1'b1;
               accept    = bit_valid;
               wr        = accept;
               shift     = accept;
               data      = bit_in & accept;
               if (cnt_term) begin
                  state_next = DONE;
               end
            end
         end

         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bit_writer_ctrl.sv
// Self-checking bench for bit_writer_ctrl with a behavioural datapath attached;
// expected write bits and transfer results are queued at drive time and popped on wr/done.
module tb_bit_writer_ctrl;

   localparam int NBITS = 8;
   localparam int CNT_W = $clog2(NBITS + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             bit_valid = 1'b0;
   logic             bit_in = 1'b0;
   logic             bit_ready;
   logic             data;
   logic             shift;
   logic             rst_mask;
   logic             wr;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] bit_cnt;

   bit_writer_ctrl #(
      .NBITS (NBITS),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .bit_ready (bit_ready),
      .data      (data),
      .shift     (shift),
      .rst_mask  (rst_mask),
      .wr        (wr),
      .busy      (busy),
      .done      (done),
      .bit_cnt   (bit_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural datapath: one-hot mask, byte fed back as old_byte.
   logic [7:0] mask;
   logic [7:0] out_byte;
   logic       dp_load = 1'b0;
   logic [7:0] dp_val  = 8'h00;

   always_ff @(posedge clk) begin
      if (rst_mask) begin
         mask <= 8'h01;
      end else if (shift) begin
         mask <= {mask[6:0], mask[7]};
      end
      if (dp_load) begin
         out_byte <= dp_val;
      end else if (wr) begin
         out_byte <= data ? (out_byte | mask) : (out_byte & ~mask);
      end
   end

   typedef struct {
      logic [7:0] byte_v;
      int         lat;
   } xfer_t;

   logic  dq[$];
   xfer_t tq[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   bit saw_done = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: drive inputs after the falling edge, observe 1 time unit later.
   task automatic tick(input logic s, input logic a, input logic v, input logic b);
      logic  exp_bit;
      xfer_t x;
      @(negedge clk);
      start     = s;
      abort     = a;
      bit_valid = v;
      bit_in    = b;
      #1;
      cyc++;
      if (wr) begin
         check("wr_expected", 32'(dq.size() > 0), 1);
         if (dq.size() > 0) begin
            exp_bit = dq.pop_front();
            check("wr_data", 32'(data), 32'(exp_bit));
            check("shift_with_wr", 32'(shift), 1);
         end
      end
      if (done) begin
         done_cnt++;
         saw_done = 1'b1;
         check("done_expected", 32'(tq.size() > 0), 1);
         if (tq.size() > 0) begin
            x = tq.pop_front();
            check("done_latency", cyc, x.lat);
            check("out_byte_at_done", 32'(out_byte), 32'(x.byte_v));
            check("bit_cnt_at_done", 32'(bit_cnt), NBITS);
         end
      end
   endtask

   task automatic preload(input logic [7:0] v);
      dp_load = 1'b1;
      dp_val  = v;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      dp_load = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_bit_ready"}, 32'(bit_ready), 0);
      check({tag, "_data"},      32'(data), 0);
      check({tag, "_shift"},     32'(shift), 0);
      check({tag, "_rst_mask"},  32'(rst_mask), 0);
      check({tag, "_wr"},        32'(wr), 0);
      check({tag, "_busy"},      32'(busy), 0);
      check({tag, "_done"},      32'(done), 0);
      check({tag, "_bit_cnt"},   32'(bit_cnt), 0);
   endtask

   task automatic run_transfer(input logic [7:0] bits, input bit bubbles, input bit noise,
                               input logic [7:0] exp_byte, input int exp_lat);
      int   n;
      int   guard;
      logic v;
      for (int i = 0; i < NBITS; i++) dq.push_back(bits[i]);
      tq.push_back('{exp_byte, exp_lat});
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("busy_at_start", 32'(busy), 0);
      cyc      = 0;
      saw_done = 1'b0;
      n        = 0;
      guard    = 0;
      while (n < NBITS && guard < 40) begin
         v = bubbles ? logic'((cyc + 1) % 2) : 1'b1;
         tick(noise, 1'b0, v, bits[n]);
         guard++;
         if (bit_ready) begin
            check("bit_cnt_write", 32'(bit_cnt), n);
            if (!v) begin
               check("bubble_no_wr", 32'(wr), 0);
               check("bubble_no_shift", 32'(shift), 0);
            end
            if (wr) n++;
         end else if (cyc == 1) begin
            check("rst_mask_in_load", 32'(rst_mask), 1);
         end
      end
      if (n < NBITS) check("accept_timeout", n, NBITS);
      guard = 0;
      while (!saw_done && guard < 20) begin
         tick(noise, 1'b0, 1'b0, 1'b0);
         guard++;
      end
      check("done_seen", 32'(saw_done), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;

      // Power-on reset.
      rst = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check_quiet("por");

      // Full transfer 1,0,1,1,0,0,1,0 from 0x00.
      preload(8'h00);
      run_transfer(8'h4D, 1'b0, 1'b0, 8'h4D, 10);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("idle_after_done_busy", 32'(busy), 0);
      check("bit_cnt_holds", 32'(bit_cnt), NBITS);

      // Same stream with a bubble every other cycle.
      preload(8'h00);
      run_transfer(8'h4D, 1'b1, 1'b0, 8'h4D, 18);

      // Overwrite from 0xFF with zeros, then back-to-back 0xA5.
      preload(8'hFF);
      run_transfer(8'h00, 1'b0, 1'b0, 8'h00, 10);
      run_transfer(8'hA5, 1'b0, 1'b0, 8'hA5, 10);

      // Abort after three accepted ones.
      preload(8'h00);
      dq.push_back(1'b1);
      dq.push_back(1'b1);
      dq.push_back(1'b1);
      d0 = done_cnt;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      check("abort_rst_mask", 32'(rst_mask), 1);
      check("abort_no_wr", 32'(wr), 0);
      check("abort_no_shift", 32'(shift), 0);
      check("abort_no_ready", 32'(bit_ready), 0);
      check("abort_bit_cnt", 32'(bit_cnt), 3);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("abort_idle_busy", 32'(busy), 0);
      check("abort_bit_cnt_clr", 32'(bit_cnt), 0);
      check("abort_out_byte", 32'(out_byte), 32'h07);
      check("abort_no_done", done_cnt, d0);

      // Start pulsed during WRITE and DONE is ignored.
      preload(8'h00);
      d0 = done_cnt;
      run_transfer(8'h3C, 1'b0, 1'b1, 8'h3C, 10);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("contention_busy", 32'(busy), 0);
      check("contention_one_done", done_cnt, d0 + 1);

      // Start and abort together in IDLE.
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("start_abort_busy", 32'(busy), 0);
      check("start_abort_rst_mask", 32'(rst_mask), 0);

      // Reset held for two cycles in mid-WRITE.
      dq.push_back(1'b1);
      dq.push_back(1'b0);
      dq.push_back(1'b1);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      check("pre_reset_bit_cnt", 32'(bit_cnt), 2);
      rst = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check_quiet("mid_reset");

      check("scoreboard_empty", 32'(dq.size() + tq.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
